ram_arbiter_2port: RTL
======================

# ram_arbiter_2port

Two-port sequencing arbiter in front of the asynchronous 64K x 8 RAM model. It turns the RAM's level-sensitive interface (address, active-low enable, active-low write, separate data in/out) into a clocked request/acknowledge interface. It shares the RAM between two requesters, port A (CPU) and port B (video/DMA), using round-robin arbitration. It sits between the bus masters and the RAM instance and is the only block that drives the RAM pins.

## Interface
- Clock and reset: one clock; reset is synchronous and active-high.
- Parameters:
  - WAIT_CYCLES, default 2: number of cycles the RAM enable is held low per access. Legal range is 1 to 15. Sized so that WAIT_CYCLES × clock period exceeds the RAM delay.
- Ports:
  - clk  in  1  system clock; all state changes on the rising edge
  - rst  in  1  synchronous, active-high reset
  - i_a_req  in  1  port A access request; held high until o_a_ack
  - i_a_write  in  1  port A: 1 = write, 0 = read
  - i_a_addr  in  16  port A address
  - i_a_data  in  8  port A write data
  - o_a_ack  out  1  port A one-cycle completion pulse
  - o_a_data  out  8  port A read data; valid with o_a_ack, held until the next port A read completes
  - i_b_req, i_b_write, i_b_addr, i_b_data, o_b_ack, o_b_data: same as port A, for port B
  - o_ram_addr  out  16  RAM address
  - o_ram_enable_x  out  1  RAM enable, active low
  - o_ram_write_x  out  1  RAM write strobe, active low
  - o_ram_data  out  8  RAM write data
  - i_ram_data  in  8  RAM read data

## Operation
- State machine: IDLE, SETUP, ACCESS, HOLD.
- IDLE:
  - Requests are sampled at the end of each IDLE cycle.
  - If exactly one req is high, that port is granted.
  - If both are high, the port not granted last time wins.
  - On a grant, latch the winner's addr, data and write into o_ram_addr, o_ram_data and a write flag; update last_grant; go to SETUP.
  - If no req is high, stay in IDLE.
- SETUP (1 cycle): address and data are stable; o_ram_enable_x = 1 and o_ram_write_x = 1. This guarantees address setup before any strobe.
- ACCESS (WAIT_CYCLES cycles):
  - o_ram_enable_x = 0.
  - o_ram_write_x = 0 for a write, 1 for a read.
  - A 4-bit wait counter loads WAIT_CYCLES−1 on entry and decrements each cycle.
  - When the counter is 0, leave for HOLD.
  - For a read, capture i_ram_data into the granted port's data register on that final edge.
- HOLD (1 cycle):
  - o_ram_enable_x = 1 and o_ram_write_x = 1; address and data are still held, giving hold time after the strobe.
  - The granted port's ack is 1.
  - Next state is IDLE.
- Port data registers:
  - Writes never change o_a_data or o_b_data.
  - A read on one port never changes the other port's data register.
- Request rules:
  - A requester must drop req on the clock edge at which it sees ack. A req still high in the following IDLE cycle is treated as a new access.
  - Changes to req, addr, data or write after a grant are ignored until the next IDLE.
- Arbitration fairness: neither port can be starved. With both ports requesting continuously, grants alternate A, B, A, B.

## Timing
- Reset values, applied on the first edge with rst = 1:
  - state = IDLE.
  - last_grant = B, so A wins the first tie.
  - o_ram_enable_x = 1, o_ram_write_x = 1.
  - o_ram_addr = 0, o_ram_data = 0.
  - o_a_ack = o_b_ack = 0.
  - o_a_data = o_b_data = 0.
- Latency: let cycle 0 be the IDLE cycle in which req is sampled high.
  - Cycle 1 is SETUP.
  - Cycles 2 to 1+WAIT_CYCLES are ACCESS.
  - Cycle 2+WAIT_CYCLES is HOLD, with ack = 1.
  - With WAIT_CYCLES = 2, ack appears in cycle 4.
- Throughput: one access per WAIT_CYCLES+3 cycles (5 cycles at the default).
- Reset mid-operation (any state):
  - Return to IDLE next cycle, with strobes deasserted and no ack issued.
  - A write in flight may or may not have landed in the RAM.
  - A requester whose req is still high is re-arbitrated as a new access.
- Both acks are never high in the same cycle.
- An ack is never high outside HOLD.

## Test plan
- Port A write, then port A read to the same address: write A=0x1234 D=0x5A, then read 0x1234. Required response: o_a_ack in cycle 4 of each access; read returns o_a_data = 0x5A; o_ram_write_x is low only during the two write ACCESS cycles.
- Port B lone read while port A is idle: read address 0xFFFF, preloaded with 0xC3. Required response: o_b_data = 0xC3, o_b_ack pulses once, o_a_ack stays 0, o_a_data is unchanged.
- Simultaneous continuous requests, A and B both reading, 6 transactions. Required response: grant order A, B, A, B, A, B; acks spaced 5 cycles apart; never two acks in one cycle.
- Reset asserted during ACCESS of a port A read. Required response: next cycle state = IDLE, o_ram_enable_x = 1, no o_a_ack; after reset deasserts with req still high, the access completes normally 4 cycles later.
- WAIT_CYCLES = 4, write 0x00 to 0x0000. Required response: o_ram_enable_x low for exactly 4 cycles; ack in cycle 6; address stable from SETUP through HOLD.
- req dropped on the ack edge versus held one extra cycle. Required response: held req produces exactly one additional access; dropped req produces none.

Source files
------------

// File: rtl/ram_arbiter_2port.sv
// ram_arbiter_2port: round-robin two-port clocked front end for an asynchronous 64Kx8 RAM
module ram_arbiter_2port #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_a_req,
    input  logic        i_a_write,
    input  logic [15:0] i_a_addr,
    input  logic [7:0]  i_a_data,
    output logic        o_a_ack,
    output logic [7:0]  o_a_data,
    input  logic        i_b_req,
    input  logic        i_b_write,
    input  logic [15:0] i_b_addr,
    input  logic [7:0]  i_b_data,
    output logic        o_b_ack,
    output logic [7:0]  o_b_data,
    output logic [15:0] o_ram_addr,
    output logic        o_ram_enable_x,
    output logic        o_ram_write_x,
    output logic [7:0]  o_ram_data,
    input  logic [7:0]  i_ram_data
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
    localparam logic [3:0] LOAD = 4'(WAIT_CYCLES - 1);
    state_t     state;
    logic       last_b;
    logic       wr;
    logic [3:0] cnt;
    logic       pick_b;
    // last_b doubles as the current grant once an access has started
    assign pick_b = (i_a_req && i_b_req) ? !last_b : i_b_req;
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_b         <= 1'b1;
            wr             <= 1'b0;
            cnt            <= 4'd0;
            o_ram_addr     <= 16'd0;
            o_ram_data     <= 8'd0;
            o_ram_enable_x <= 1'b1;
            o_ram_write_x  <= 1'b1;
            o_a_ack        <= 1'b0;
            o_b_ack        <= 1'b0;
            o_a_data       <= 8'd0;
            o_b_data       <= 8'd0;
        end else begin
            case (state)
                IDLE: if (i_a_req || i_b_req) begin
                    last_b     <= pick_b;
                    o_ram_addr <= pick_b ? i_b_addr : i_a_addr;
                    o_ram_data <= pick_b ? i_b_data : i_a_data;
                    wr         <= pick_b ? i_b_write : i_a_write;
                    state      <= SETUP;
                end
                SETUP: begin
                    o_ram_enable_x <= 1'b0;
                    o_ram_write_x  <= !wr;
                    cnt            <= LOAD;
                    state          <= ACCESS;
                end
                ACCESS: if (cnt == 4'd0) begin
                    o_ram_enable_x <= 1'b1;
                    o_ram_write_x  <= 1'b1;
                    o_a_ack        <= !last_b;
                    o_b_ack        <= last_b;
                    o_a_data       <= (!wr && !last_b) ? i_ram_data : o_a_data;
                    o_b_data       <= (!wr && last_b) ? i_ram_data : o_b_data;
                    state          <= HOLD;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                HOLD: begin
                    o_a_ack <= 1'b0;
                    o_b_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
